// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Constants and types shared by the RV32 pipeline stages.
//   XLEN_DEFAULT  : default width of pc and instruction fields
//   NOP_INSTR     : canonical bubble instruction, addi x0,x0,0
//   fetch_entry_t : one {pc, instr} pair moving from IF to ID
package rv32_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   Multi-entry decoupling buffer between IF and ID. It holds {pc, instr}
//   pairs so that fetch can run up to DEPTH instructions ahead of a
//   stalled decode. A flush empties it in one cycle. While it is empty,
//   ID sees a NOP bubble with pc 0.
//
//   Parameters
//     XLEN  : width of pc and instruction fields
//     DEPTH : number of entries (power of two, at least 2)
//     NOP   : instruction presented while empty
//   Ports
//     clk, rst_          : rising-edge clock, async active-low reset
//     flush              : discard all contents (redirect / branch taken)
//     in_valid/in_ready  : IF-side handshake; in_ready depends only on state
//     in_pc, in_instr    : fetched pair
//     out_valid/out_ready: ID-side handshake (out_ready = !stall)
//     out_pc, out_instr  : head entry, or 0 / NOP while empty
//     count              : occupied entries
module fetch_queue
   import rv32_pkg::*;
#(
   parameter int unsigned     XLEN  = XLEN_DEFAULT,
   parameter int unsigned     DEPTH = 2,
   parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INSTR)
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // Pointers carry one extra wrap bit above the index so that full and
   // empty are distinguishable without a separate occupancy counter.
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic empty;
   logic full;
   logic push;
   logic pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A full queue refuses a push even when a pop happens in the same cycle,
   // which keeps in_ready free of any path from out_ready.
   assign push = in_valid && !full && !flush;
   assign pop  = !empty && out_ready && !flush;

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values, regardless of the order of statements.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone
   // define which entries are meaningful, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr[AW-1:0]]    <= in_pc;
         instr_mem[wr_ptr[AW-1:0]] <= in_instr;
      end
   end

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_pc    = empty ? '0  : pc_mem[rd_ptr[AW-1:0]];
   assign out_instr = empty ? NOP : instr_mem[rd_ptr[AW-1:0]];
   assign count     = wr_ptr - rd_ptr;

endmodule
